// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar measurement path: FSM state codes, default timing constants, BCD limits.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: estado_t (4-bit codes, also decoded by the hex debug path), CICLOS_*_PADRAO,
//           BCD_MAX, BCD_TIMEOUT, bcd_incrementa() (saturating 3-digit BCD increment).
package sonar_pkg;

   typedef enum logic [3:0] {
      INICIAL       = 4'h0,
      PREPARA       = 4'h1,
      ENVIA_TRIGGER = 4'h2,
      ESPERA_ECHO   = 4'h3,
      MEDINDO       = 4'h4,
      ARMAZENA      = 4'h5,
      FINAL         = 4'h6
   } estado_t;

   // Defaults for a 50 MHz clock
   localparam int CICLOS_TRIGGER_PADRAO = 500;        // 10 us
   localparam int CICLOS_CM_PADRAO      = 2941;       // 58.82 us of echo per cm
   localparam int CICLOS_TIMEOUT_PADRAO = 1_500_000;  // 30 ms

   localparam logic [11:0] BCD_MAX     = 12'h999;
   localparam logic [11:0] BCD_TIMEOUT = 12'hFFF;

   // Adds one to a 3-digit BCD value; 999 stays at 999.
   function automatic logic [11:0] bcd_incrementa(input logic [11:0] v);
      logic [3:0] c, d, u;
      {c, d, u} = v;
      if (v != BCD_MAX) begin
         if (u != 4'd9) begin
            u = u + 4'd1;
         end else begin
            u = 4'd0;
            if (d != 4'd9) begin
               d = d + 4'd1;
            end else begin
               d = 4'd0;
               c = c + 4'd1;
            end
         end
      end
      return {c, d, u};
   endfunction

endpackage

// File: rtl/contador_bcd_cm.sv
// 3-digit BCD centimetre counter with synchronous clear, count enable and saturation at 999.
// Latency: 1 clock from limpa/conta to the registered count; proximo shows the next value combinationally.
// Backpressure: none; every enabled cycle counts.
// Ports: clock, reset (sync, active-high), limpa (clear, wins over conta), conta (increment),
//        proximo[11:0] (value the counter takes at the next edge, so a caller can register it in step).
module contador_bcd_cm
   import sonar_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        limpa,
   input  logic        conta,
   output logic [11:0] proximo
);

   logic [11:0] valor;

   always_comb begin
      proximo = valor;
      if (limpa) begin
         proximo = 12'h000;
      end else if (conta) begin
         proximo = bcd_incrementa(valor);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valor <= 12'h000;
      end else begin
         valor <= proximo;
      end
   end

endmodule

// File: rtl/interface_hcsr04_medida.sv
// HC-SR04 front end: fires the trigger, times the echo and returns the distance in cm (rounded) as 3-digit BCD.
// Latency: pronto rises 2 clocks after the first clock the synchronized echo reads 0 (4 clocks after the pin falls).
// Backpressure: none; medir is only looked at in INICIAL, requests arriving elsewhere are dropped.
// Ports: clock, reset (sync, active-high), medir (start), echo (async pin), trigger, medida[11:0] BCD cm,
//        pronto (1-cycle result strobe), timeout (1-cycle abort strobe, with pronto), db_estado[3:0] (state code).
// Option: define INTERFACE_HCSR04_TIMEOUT_EN to abort after CICLOS_TIMEOUT clocks in ESPERA_ECHO+MEDINDO
//         (medida=FFF, timeout with pronto); otherwise the FSM waits for echo forever and timeout stays 0.
module interface_hcsr04_medida
   import sonar_pkg::*;
#(
   parameter int CICLOS_TRIGGER = CICLOS_TRIGGER_PADRAO,
   parameter int CICLOS_CM      = CICLOS_CM_PADRAO,
   parameter int CICLOS_TIMEOUT = CICLOS_TIMEOUT_PADRAO
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        medir,
   input  logic        echo,
   output logic        trigger,
   output logic [11:0] medida,
   output logic        pronto,
   output logic        timeout,
   output logic [3:0]  db_estado
);

   // One tick counter serves the trigger width and, when enabled, the timeout.
   localparam int TW = $clog2(CICLOS_TRIGGER + CICLOS_TIMEOUT + 1);
   localparam int RW = $clog2(CICLOS_CM + 1);

   localparam logic [TW-1:0] TICK_TRIGGER_FIM = TW'(CICLOS_TRIGGER - 1);
   localparam logic [RW-1:0] RES_FIM          = RW'(CICLOS_CM - 1);
   localparam logic [RW-1:0] RES_META         = RW'(CICLOS_CM / 2);

   estado_t       estado;
   logic [TW-1:0] tick;
   logic [RW-1:0] residual;
   logic [RW-1:0] residual_prox;
   logic          echo_m, echo_s, echo_s_d;
   logic          subida_echo;
   logic          conta_eco;
   logic          bcd_limpa, bcd_conta;
   logic [11:0]   bcd_prox;
   logic          estouro;

   // Two-flop synchronizer, plus one more stage for edge detection.
   always_ff @(posedge clock) begin
      if (reset) begin
         echo_m   <= 1'b0;
         echo_s   <= 1'b0;
         echo_s_d <= 1'b0;
      end else begin
         echo_m   <= echo;
         echo_s   <= echo_m;
         echo_s_d <= echo_s;
      end
   end

   assign subida_echo = echo_s & ~echo_s_d;

   // The rising-edge cycle is already a high echo cycle, so it is counted too.
   assign conta_eco     = (estado == MEDINDO && echo_s) || (estado == ESPERA_ECHO && subida_echo);
   assign residual_prox = (residual == RES_FIM) ? '0 : residual + 1'b1;

   // Whole-cm carries during the echo, plus the single round-half-up step in ARMAZENA.
   assign bcd_limpa = (estado == PREPARA);
   assign bcd_conta = (conta_eco && residual == RES_FIM) ||
                      (estado == ARMAZENA && residual >= RES_META);

   contador_bcd_cm u_contador_bcd_cm (
      .clock   (clock),
      .reset   (reset),
      .limpa   (bcd_limpa),
      .conta   (bcd_conta),
      .proximo (bcd_prox)
   );

`ifdef INTERFACE_HCSR04_TIMEOUT_EN
   assign estouro = (estado == ESPERA_ECHO || estado == MEDINDO) &&
                    (tick == TW'(CICLOS_TIMEOUT - 1));
`else
   assign estouro = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         estado   <= INICIAL;
         trigger  <= 1'b0;
         medida   <= 12'h000;
         pronto   <= 1'b0;
         timeout  <= 1'b0;
         tick     <= '0;
         residual <= '0;
      end else begin
         pronto  <= 1'b0;
         timeout <= 1'b0;
         case (estado)
            INICIAL: begin
               if (medir) estado <= PREPARA;
            end
            PREPARA: begin
               tick     <= '0;
               residual <= '0;
               trigger  <= 1'b1;
               estado   <= ENVIA_TRIGGER;
            end
            ENVIA_TRIGGER: begin
               if (tick == TICK_TRIGGER_FIM) begin
                  tick    <= '0;   // restarts as the timeout count
                  trigger <= 1'b0;
                  estado  <= ESPERA_ECHO;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            ESPERA_ECHO, MEDINDO: begin
`ifdef INTERFACE_HCSR04_TIMEOUT_EN
               tick <= tick + 1'b1;
`endif
               if (estouro) begin
                  medida  <= BCD_TIMEOUT;
                  pronto  <= 1'b1;
                  timeout <= 1'b1;
                  estado  <= INICIAL;
               end else if (estado == ESPERA_ECHO) begin
                  if (subida_echo) begin
                     residual <= residual_prox;
                     estado   <= MEDINDO;
                  end
               end else if (echo_s) begin
                  residual <= residual_prox;
               end else begin
                  estado <= ARMAZENA;
               end
            end
            ARMAZENA: begin
               // bcd_prox already includes the rounding increment taken this cycle.
               medida <= bcd_prox;
               pronto <= 1'b1;
               estado <= FINAL;
            end
            FINAL: begin
               estado <= INICIAL;
            end
            default: estado <= INICIAL;
         endcase
      end
   end

   assign db_estado = estado;

endmodule

// File: tb/tb_interface_hcsr04_medida.sv
module tb_interface_hcsr04_medida;

   localparam int CT = 10;    // trigger clocks
   localparam int CM = 20;    // clocks per cm
   localparam int TO = 4000;  // timeout clocks (only with the option defined)

   logic        clock = 1'b0;
   logic        reset, medir, echo;
   logic        trigger, pronto, timeout;
   logic [11:0] medida;
   logic [3:0]  db_estado;

   int          n_testes = 0;
   int          n_falhas = 0;
   int          n_pronto = 0;
   int          ciclo = 0;
   int          ciclo_pronto = 0;
   logic [11:0] medida_cap = 12'h000;
   logic        timeout_cap = 1'b0;
   logic        pronto_ant = 1'b0;

   always #10 clock = ~clock;

   interface_hcsr04_medida #(
      .CICLOS_TRIGGER (CT),
      .CICLOS_CM      (CM),
      .CICLOS_TIMEOUT (TO)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .medir     (medir),
      .echo      (echo),
      .trigger   (trigger),
      .medida    (medida),
      .pronto    (pronto),
      .timeout   (timeout),
      .db_estado (db_estado)
   );

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_testes++;
      if (obs !== esp) begin
         n_falhas++;
         $display("FAIL %s: obtido %0h esperado %0h", tag, obs, esp);
      end
   endtask

   // Reference: distance = echo clocks / CM rounded half up, clipped at 999, as BCD.
   function automatic logic [11:0] modelo_cm(input int n_ciclos, input bit aborta);
      int cm;
      if (aborta) return 12'hFFF;
      cm = n_ciclos / CM;
      if ((n_ciclos % CM) >= CM / 2) cm = cm + 1;
      if (cm > 999) cm = 999;
      return {4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
   endfunction

   // Captures every pronto strobe on the falling edge.
   always @(negedge clock) begin
      ciclo++;
      if (pronto) begin
         n_pronto++;
         ciclo_pronto = ciclo;
         medida_cap   = medida;
         timeout_cap  = timeout;
         verifica("pronto_1ciclo", pronto_ant, 0);
      end
      pronto_ant = pronto;
   end

   // One measurement: optional 5-cycle medir pulse, trigger width check, echo of n clocks
   // starting gap clocks after the trigger ends, then result / strobe / latency checks.
   task automatic mede(input string tag, input int n, input int gap,
                       input bit pulsa_medir, input bit pulso_meio);
      int          t_alto;
      int          n0;
      int          ciclo_queda;
      int          budget;
      bit          aborta;
      logic [11:0] esp;
      aborta = 1'b0;
`ifdef INTERFACE_HCSR04_TIMEOUT_EN
      aborta = (n == 0) || (gap + n >= TO);
`endif
      esp    = modelo_cm(n, aborta);
      n0     = n_pronto;
      t_alto = 0;
      if (pulsa_medir) begin
         @(posedge clock);
         #1 medir = 1'b1;
      end
      for (int c = 0; c < CT + 50; c++) begin
         @(negedge clock);
         if (pulsa_medir && c == 5) medir = 1'b0;
         if (trigger) t_alto++;
         else if (t_alto > 0) break;
      end
      medir = pulsa_medir ? 1'b0 : medir;
      verifica({tag, "_trigger_larg"}, t_alto, CT);
      repeat (gap + 1) @(posedge clock);
      ciclo_queda = ciclo;
      if (n > 0) begin
         #1 echo = 1'b1;
         for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (pulso_meio && i == n / 2)     medir = 1'b1;
            if (pulso_meio && i == n / 2 + 3) medir = 1'b0;
         end
         echo = 1'b0;
         ciclo_queda = ciclo;
      end
      budget = aborta ? TO + 100 : 20;
      for (int k = 0; k < budget && n_pronto == n0; k++) @(posedge clock);
      verifica({tag, "_n_pronto"}, n_pronto - n0, 1);
      verifica({tag, "_medida"}, medida_cap, esp);
      verifica({tag, "_timeout"}, timeout_cap, aborta);
      // 2 sync stages + MEDINDO exit + ARMAZENA: strobe seen on the 5th falling edge after the drop.
      if (!aborta) verifica({tag, "_latencia"}, ciclo_pronto - ciclo_queda, 5);
   endtask

   initial begin
      int n0;
      reset = 1'b1;
      medir = 1'b0;
      echo  = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      verifica("rst_trigger", trigger, 0);
      verifica("rst_medida", medida, 12'h000);
      verifica("rst_pronto", pronto, 0);
      verifica("rst_timeout", timeout, 0);
      verifica("rst_estado", db_estado, 4'h0);

      mede("c100", 100 * CM + 5, 7, 1'b1, 1'b0);
      mede("c075", 74 * CM + 16, 3, 1'b1, 1'b0);
      mede("c009_meio", 8 * CM + CM / 2, 5, 1'b1, 1'b0);
      mede("c008_abaixo", 8 * CM + CM / 2 - 1, 0, 1'b1, 1'b0);
      mede("c020", 20 * CM, 9, 1'b1, 1'b0);
      mede("c000_curto", 1, 4, 1'b1, 1'b0);
      mede("sat_arred", 999 * CM + CM / 2, 2, 1'b1, 1'b0);
      mede("sat_longo", 21000, 6, 1'b1, 1'b0);
`ifdef INTERFACE_HCSR04_TIMEOUT_EN
      mede("sem_eco", 0, 0, 1'b1, 1'b0);
`endif
      mede("c033", 33 * CM + 4, 1, 1'b1, 1'b0);

      // Reset in the middle of the trigger pulse.
      n0 = n_pronto;
      @(posedge clock);
      #1 medir = 1'b1;
      repeat (5) @(posedge clock);
      #1 medir = 1'b0;
      @(negedge clock);
      verifica("rst_trig_pre", trigger, 1);
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      verifica("rst_trig_trigger", trigger, 0);
      verifica("rst_trig_medida", medida, 12'h000);
      verifica("rst_trig_estado", db_estado, 4'h0);
      verifica("rst_trig_pronto", pronto, 0);

      // Reset in the middle of the echo.
      @(posedge clock);
      #1 medir = 1'b1;
      repeat (5) @(posedge clock);
      #1 medir = 1'b0;
      repeat (CT + 5) @(posedge clock);
      #1 echo = 1'b1;
      repeat (40) @(posedge clock);
      @(negedge clock);
      verifica("rst_eco_pre", db_estado, 4'h4);
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      verifica("rst_eco_trigger", trigger, 0);
      verifica("rst_eco_medida", medida, 12'h000);
      verifica("rst_eco_estado", db_estado, 4'h0);
      echo = 1'b0;
      repeat (30) @(posedge clock);
      @(negedge clock);
      verifica("rst_sem_pronto", n_pronto - n0, 0);
      mede("c017_pos_rst", 17 * CM, 5, 1'b1, 1'b0);

      // medir pulsed while measuring must not start another pass.
      n0 = n_pronto;
      mede("medir_meio", 30 * CM + 3, 4, 1'b1, 1'b1);
      repeat (30) @(posedge clock);
      @(negedge clock);
      verifica("medir_meio_um_pronto", n_pronto - n0, 1);
      verifica("medir_meio_estado", db_estado, 4'h0);

      // medir held high: back-to-back passes.
      n0 = n_pronto;
      @(posedge clock);
      #1 medir = 1'b1;
      mede("seguido1", 12 * CM + 15, 3, 1'b0, 1'b0);
      mede("seguido2", 45 * CM + 2, 8, 1'b0, 1'b0);
      #1 medir = 1'b0;
      verifica("seguido_n_pronto", n_pronto - n0, 2);

      for (int r = 0; r < 16; r++) begin
         mede("aleat", $urandom_range(60 * CM, 1), $urandom_range(20, 0), 1'b1, 1'b0);
      end

      repeat (5) @(posedge clock);
      $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
      $finish;
   end

endmodule
